// File: rtl/imem_line_fill.sv
// Line-fill engine: turns one cache-line miss into four back-to-back imem reads and streams the beats in order.
// Optional pre-issue wait state is compiled in with `define IMEM_FILL_DELAY_EN.
module imem_line_fill #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 22,
    parameter int BEAT_STRIDE   = 2,
    parameter int MEM_LATENCY   = 1,
    parameter int FILL_DELAY    = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Req_Valid,
    input  logic [ADDRESS_WIDTH-1:0] i_Req_Address,
    output logic                     o_MEM_Valid,
    output logic                     o_MEM_Last,
    output logic [DATA_WIDTH-1:0]    o_MEM_Data,
    output logic                     o_IMEM_Rd,
    output logic [ADDRESS_WIDTH-1:0] o_IMEM_Addr,
    input  logic [DATA_WIDTH-1:0]    i_IMEM_Data,
    output logic                     o_Busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_TURN  = 3'd4
    } state_t;

`ifdef IMEM_FILL_DELAY_EN
    localparam state_t FIRST_STATE = (FILL_DELAY > 0) ? S_WAIT : S_ISSUE;
    localparam int     DW          = (FILL_DELAY > 0) ? $clog2(FILL_DELAY + 1) : 1;
    logic [DW-1:0]     delay_cnt_reg;
`else
    localparam state_t FIRST_STATE = S_ISSUE;
`endif

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 4 || FILL_DELAY < 0) begin : g_bad_param
            $error("imem_line_fill: MEM_LATENCY must be 1..4 and FILL_DELAY non-negative");
        end
    endgenerate

    state_t                     state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0]   base_reg;
    logic [1:0]                 issue_cnt_reg;
    logic [MEM_LATENCY-1:0]     sr_valid_reg;
    logic [2*MEM_LATENCY-1:0]   sr_tag_reg;
    logic                       mem_valid_reg;
    logic                       mem_last_reg;
    logic [DATA_WIDTH-1:0]      mem_data_reg;
    logic                       accept;
    logic                       abort;
    logic                       rd;
    logic                       tail_valid;
    logic                       tail_last;
    logic [ADDRESS_WIDTH-1:0]   issue_addr;

    assign tail_valid = sr_valid_reg[MEM_LATENCY-1];
    assign tail_last  = tail_valid && (sr_tag_reg[2*MEM_LATENCY-1 -: 2] == 2'd3);

    // Strobe is gated by the live request so an abort never launches one more read.
    assign rd         = (state_reg == S_ISSUE) && i_Req_Valid;
    assign issue_addr = base_reg + ADDRESS_WIDTH'(issue_cnt_reg) * ADDRESS_WIDTH'(BEAT_STRIDE);

    assign o_IMEM_Rd   = rd;
    assign o_IMEM_Addr = rd ? issue_addr : '0;
    assign o_Busy      = (state_reg != S_IDLE);
    assign o_MEM_Valid = mem_valid_reg;
    assign o_MEM_Last  = mem_last_reg;
    assign o_MEM_Data  = mem_data_reg;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (i_Req_Valid) begin
                    accept     = 1'b1;
                    state_next = FIRST_STATE;
                end
            end
`ifdef IMEM_FILL_DELAY_EN
            S_WAIT: begin
                if (!i_Req_Valid)
                    abort = 1'b1;
                else if (delay_cnt_reg <= DW'(1))
                    state_next = S_ISSUE;
            end
`endif
            S_ISSUE: begin
                if (!i_Req_Valid)
                    abort = 1'b1;
                else if (issue_cnt_reg == 2'd3)
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!i_Req_Valid)
                    abort = 1'b1;
                else if (tail_last)
                    state_next = S_TURN;
            end
            // The cache is still dropping its request here, so it is not looked at.
            S_TURN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort)
            state_next = S_IDLE;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_reg     <= S_IDLE;
            base_reg      <= '0;
            issue_cnt_reg <= '0;
            mem_valid_reg <= 1'b0;
            mem_last_reg  <= 1'b0;
            mem_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                base_reg      <= i_Req_Address;
                issue_cnt_reg <= '0;
            end else if (rd) begin
                issue_cnt_reg <= issue_cnt_reg + 2'd1;
            end
            mem_valid_reg <= tail_valid && !abort;
            mem_last_reg  <= tail_last && !abort;
            if (tail_valid && !abort)
                mem_data_reg <= i_IMEM_Data;
        end
    end

    // Valid/tag pipeline mirrors the imem read latency; clearing it squashes in-flight reads.
    generate
        if (MEM_LATENCY == 1) begin : g_sr_single
            always_ff @(posedge i_Clk) begin
                if (i_Reset || abort) begin
                    sr_valid_reg <= '0;
                    sr_tag_reg   <= '0;
                end else begin
                    sr_valid_reg <= rd;
                    sr_tag_reg   <= issue_cnt_reg;
                end
            end
        end else begin : g_sr_multi
            always_ff @(posedge i_Clk) begin
                if (i_Reset || abort) begin
                    sr_valid_reg <= '0;
                    sr_tag_reg   <= '0;
                end else begin
                    sr_valid_reg <= {sr_valid_reg[MEM_LATENCY-2:0], rd};
                    sr_tag_reg   <= {sr_tag_reg[2*MEM_LATENCY-3:0], issue_cnt_reg};
                end
            end
        end
    endgenerate

`ifdef IMEM_FILL_DELAY_EN
    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            delay_cnt_reg <= '0;
        else if (accept)
            delay_cnt_reg <= DW'(FILL_DELAY);
        else if (state_reg == S_WAIT)
            delay_cnt_reg <= delay_cnt_reg - DW'(1);
    end
`endif

endmodule
